// File: rtl/back_error_calculation_vec.sv
// IEEE-754 single multiplier, round-to-nearest-even, denormals flushed to zero, canonical NaN 0x7FC00000.
// Latency: 7 cycles from valid_in to valid_out, one operand pair per cycle.
// Backpressure: none; every accepted pair emerges, reset clears everything in flight.
module multiplier_floating_point32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] result
);
    logic [31:0]      a_q, b_q, res_c;
    logic [6:0]       vld_sr;
    logic [6:1][31:0] res_sr;

    logic        sign, guard, sticky;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [22:0] mant;
    logic [23:0] mant_r;
    int          e;

    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        prod   = {1'b1, a_q[22:0]} * {1'b1, b_q[22:0]};
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e      = int'(a_q[30:23]) + int'(b_q[30:23]) - 126;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            e      = int'(a_q[30:23]) + int'(b_q[30:23]) - 127;
        end
        mant_r = {1'b0, mant} + 24'(guard && (sticky || mant[0]));
        // A rounding carry leaves the fraction at zero and bumps the exponent.
        if (mant_r[23]) e = e + 1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res_c = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            res_c = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero || e <= 0)
            res_c = {sign, 31'd0};
        else if (e >= 255)
            res_c = {sign, 8'hFF, 23'd0};
        else
            res_c = {sign, e[7:0], mant_r[22:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            vld_sr <= '0;
            res_sr <= '0;
        end else begin
            a_q       <= a;
            b_q       <= b;
            vld_sr    <= {vld_sr[5:0], valid_in};
            res_sr[1] <= res_c;
            for (int i = 2; i <= 6; i++) res_sr[i] <= res_sr[i-1];
        end
    end

    assign valid_out = vld_sr[6];
    assign result    = res_sr[6];
endmodule

// Back-propagation weight error: computes (delta*LR) once, then streams delta*LR*x for NUM_POINTS points.
// Latency: 7 cycles per point after acceptance; first point accepted 8 cycles after start.
// Backpressure: o_ready gates i_valid; unaccepted points are dropped, outputs cannot be stalled.
module back_error_calculation_vec #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] LEARNING_RATE = 'h3B03126F,
    parameter int                    NUM_POINTS    = 64,
    parameter int                    INDEX_WIDTH   = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [DATA_WIDTH-1:0]  i_delta,
    input  logic [DATA_WIDTH-1:0]  i_learning_rate,
    input  logic                   i_lr_override,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data_point,
    output logic                   o_ready,
    output logic [DATA_WIDTH-1:0]  o_error,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_valid,
    output logic                   o_last,
    output logic                   o_busy
);
    localparam int CNT_W = $clog2(NUM_POINTS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCALE  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]            state;
    logic [CNT_W-1:0]      in_count;
    logic [INDEX_WIDTH-1:0] out_count;
    logic [DATA_WIDTH-1:0] scaled_delta;

    logic                  accept, stream_out;
    logic                  mul_vld_in, mul_vld_out;
    logic [31:0]           mul_a, mul_b, mul_res;

    assign o_ready    = (state == STREAM) && (in_count < CNT_W'(NUM_POINTS));
    assign accept     = o_ready && i_valid;
    // The only result that can emerge in SCALE is delta*LR; it never reaches o_valid.
    assign stream_out = mul_vld_out && ((state == STREAM) || (state == DRAIN));

    assign mul_vld_in = ((state == IDLE) && i_start) || accept;
    assign mul_a      = (state == IDLE) ? i_delta : scaled_delta;
    assign mul_b      = (state == IDLE) ? (i_lr_override ? i_learning_rate : LEARNING_RATE)
                                        : i_data_point;

    multiplier_floating_point32 u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (mul_vld_in),
        .a         (mul_a),
        .b         (mul_b),
        .valid_out (mul_vld_out),
        .result    (mul_res)
    );

    assign o_valid = stream_out;
    assign o_error = stream_out ? mul_res : '0;
    assign o_index = out_count;
    assign o_last  = stream_out && (out_count == INDEX_WIDTH'(NUM_POINTS - 1));
    assign o_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_count     <= '0;
            out_count    <= '0;
            scaled_delta <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) state <= SCALE;
                SCALE: if (mul_vld_out) begin
                    scaled_delta <= mul_res;
                    state        <= STREAM;
                end
                STREAM: if (accept) begin
                    in_count <= in_count + 1'b1;
                    if (in_count == CNT_W'(NUM_POINTS - 1)) state <= DRAIN;
                end
                default: if (o_last) state <= IDLE;
            endcase

            if (o_last) begin
                in_count  <= '0;
                out_count <= '0;
            end else if (stream_out) begin
                out_count <= out_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_back_error_calculation_vec.sv
// Scoreboard bench: drivers push expected results on acceptance, a negedge monitor pops and compares.
module tb_back_error_calculation_vec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NUM_POINTS=4 instance
    logic        start = 0, ovr = 0, vld = 0;
    logic [31:0] delta = 0, lr = 0, x = 0;
    logic        ready, ovld, last, busy;
    logic [31:0] err;
    logic [1:0]  idx;

    // NUM_POINTS=1 instance
    logic        s_start = 0, s_ovr = 0, s_vld = 0;
    logic [31:0] s_delta = 0, s_lr = 0, s_x = 0;
    logic        s_ready, s_ovld, s_last, s_busy;
    logic [31:0] s_err;
    logic [0:0]  s_idx;

    back_error_calculation_vec #(.NUM_POINTS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_delta(delta), .i_learning_rate(lr),
        .i_lr_override(ovr), .i_valid(vld), .i_data_point(x), .o_ready(ready), .o_error(err),
        .o_index(idx), .o_valid(ovld), .o_last(last), .o_busy(busy));

    back_error_calculation_vec #(.NUM_POINTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_delta(s_delta), .i_learning_rate(s_lr),
        .i_lr_override(s_ovr), .i_valid(s_vld), .i_data_point(s_x), .o_ready(s_ready), .o_error(s_err),
        .o_index(s_idx), .o_valid(s_ovld), .o_last(s_last), .o_busy(s_busy));

    typedef struct {
        logic [31:0] err;
        int          idx;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          batch_idx = 0;
    logic [31:0] xs[4], es[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: every o_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ovld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got index %0d error %h, expected no output", idx, err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("o_error", err, mon_e.err);
                chk("o_index", 32'(idx), 32'(mon_e.idx));
                chk("o_last", 32'(last), 32'(mon_e.idx == 3));
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input logic [31:0] d, input logic [31:0] l, input logic o);
        int  sc;
        bit  got;
        start = 1; delta = d; lr = l; ovr = o;
        @(negedge clk);
        sc = cyc;
        tick();
        start = 0; delta = 32'h4120_0000; lr = 32'h4120_0000; ovr = ~o;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1;
        end
        chk("ready_rise_delay", cyc - sc, 8);
        tick();
        batch_idx = 0;
    endtask

    task automatic send_point(input logic [31:0] xv, input logic [31:0] ev, input bit gap);
        bit   got;
        exp_t e;
        vld = 1; x = xv;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready) begin
                e.err = ev; e.idx = batch_idx; e.cyc = cyc + 7;
                exp_q.push_back(e);
                got = 1;
            end
            tick();
        end
        vld = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no o_ready, expected acceptance of point %0d", batch_idx);
        end
        batch_idx++;
        if (gap) tick();
    endtask

    task automatic finish_batch();
        @(negedge clk);
        chk("ready_after_last", 32'(ready), 0);
        tick();
        // Offered points while o_ready is low must be dropped.
        vld = 1; x = 32'h3F80_0000;
        repeat (3) tick();
        vld = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("outstanding_results", exp_q.size(), 0);
        chk("busy_after_batch", 32'(busy), 0);
        tick();
    endtask

    task automatic run_batch(input logic [31:0] d, input logic [31:0] l, input logic o,
                             input bit gap, input bit mid_start);
        start_batch(d, l, o);
        for (int i = 0; i < 4; i++) begin
            if (mid_start && i == 1) begin
                start = 1; delta = 32'h4080_0000; lr = 32'h3F80_0000; ovr = 1;
            end
            send_point(xs[i], es[i], gap);
            start = 0;
        end
        finish_batch();
    endtask

    initial begin
        int sc;
        bit got;
        #2;
        chk("reset_o_valid", 32'(ovld), 0);
        chk("reset_o_last", 32'(last), 0);
        chk("reset_o_ready", 32'(ready), 0);
        chk("reset_o_busy", 32'(busy), 0);
        chk("reset_o_error", err, 0);
        chk("reset_o_index", 32'(idx), 0);
        repeat (3) tick();
        rst_n = 1;
        tick();

        // Default LR 0.002, delta 2.0, x = 1.0 back to back
        xs = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        es = '{32'h3B83_126F, 32'h3B83_126F, 32'h3B83_126F, 32'h3B83_126F};
        run_batch(32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Runtime LR 1.0, delta 2.0 -> scale 2.0
        xs = '{32'h4040_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h0000_0000};
        es = '{32'h40C0_0000, 32'hC000_0000, 32'h3F80_0000, 32'h0000_0000};
        run_batch(32'h4000_0000, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);

        // LR 0.5, delta 4.0 -> scale 2.0, points on alternate cycles
        xs = '{32'h3FC0_0000, 32'h4000_0000, 32'hBE80_0000, 32'h4120_0000};
        es = '{32'h4040_0000, 32'h4080_0000, 32'hBF00_0000, 32'h41A0_0000};
        run_batch(32'h4080_0000, 32'h3F00_0000, 1'b1, 1'b1, 1'b0);

        // Scale 1.0; a start pulse with delta 4.0 mid-stream must be ignored
        xs = '{32'h40E0_0000, 32'h3F80_0000, 32'h4000_0000, 32'hC120_0000};
        es = '{32'h40E0_0000, 32'h3F80_0000, 32'h4000_0000, 32'hC120_0000};
        run_batch(32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0, 1'b1);

        // Reset after two accepted points
        start_batch(32'h4000_0000, 32'h0, 1'b0);
        send_point(32'h3F80_0000, 32'h3B83_126F, 1'b0);
        send_point(32'h3F80_0000, 32'h3B83_126F, 1'b0);
        #2 rst_n = 0;
        #1;
        chk("midreset_o_valid", 32'(ovld), 0);
        chk("midreset_o_ready", 32'(ready), 0);
        chk("midreset_o_busy", 32'(busy), 0);
        chk("midreset_o_last", 32'(last), 0);
        chk("midreset_o_error", err, 0);
        chk("midreset_o_index", 32'(idx), 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1;
        repeat (15) tick();
        chk("busy_after_reset", 32'(busy), 0);

        // Full batch after reset: tie-to-even rounding, infinity, negative zero
        xs = '{32'h3F80_0000, 32'h4040_0000, 32'h7F80_0000, 32'h8000_0000};
        es = '{32'h3B83_126F, 32'h3C44_9BA6, 32'h7F80_0000, 32'h8000_0000};
        run_batch(32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Single-point instance
        s_start = 1; s_delta = 32'h4000_0000; s_lr = 32'h3F80_0000; s_ovr = 1;
        tick();
        s_start = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1;
        end
        chk("single_ready_seen", 32'(got), 1);
        tick();
        s_vld = 1; s_x = 32'h4040_0000;
        @(negedge clk);
        sc = cyc;
        tick();
        s_vld = 0;
        @(negedge clk);
        chk("single_ready_after_accept", 32'(s_ready), 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (s_ovld) got = 1;
            else @(negedge clk);
        end
        chk("single_latency", cyc - sc, 7);
        chk("single_o_error", s_err, 32'h40C0_0000);
        chk("single_o_index", 32'(s_idx), 0);
        chk("single_o_last", 32'(s_last), 1);
        @(negedge clk);
        chk("single_busy_after_last", 32'(s_busy), 0);
        chk("single_no_second_valid", 32'(s_ovld), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
